// File: rtl/vga_pkg.sv
// Shared widths, pixel word layout and grant encoding for the pixel write arbiter.
package vga_pkg;
    localparam int nX          = 10;
    localparam int nY          = 9;
    localparam int COLOR_DEPTH = 9;
    localparam int PIX_W       = nX + nY + COLOR_DEPTH;

    typedef struct packed {
        logic [nX-1:0]          x;
        logic [nY-1:0]          y;
        logic [COLOR_DEPTH-1:0] color;
    } pixel_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    function automatic logic [PIX_W-1:0] pack_pixel(input logic [nX-1:0] x,
                                                   input logic [nY-1:0] y,
                                                   input logic [COLOR_DEPTH-1:0] color);
        return {x, y, color};
    endfunction

    function automatic pixel_t unpack_pixel(input logic [PIX_W-1:0] word);
        return pixel_t'(word);
    endfunction
endpackage

// File: rtl/pixel_write_arbiter_if.sv
// Bundle of both engine write ports and the VGA adapter write port.
interface pixel_write_arbiter_if;
    import vga_pkg::*;

    logic [nX-1:0]          a_x;
    logic [nY-1:0]          a_y;
    logic [COLOR_DEPTH-1:0] a_color;
    logic                   a_write;
    logic                   a_ready;
    logic [nX-1:0]          b_x;
    logic [nY-1:0]          b_y;
    logic [COLOR_DEPTH-1:0] b_color;
    logic                   b_write;
    logic                   b_ready;
    logic                   clear_overflow;
    logic [nX-1:0]          VGA_x;
    logic [nY-1:0]          VGA_y;
    logic [COLOR_DEPTH-1:0] VGA_color;
    logic                   VGA_write;
    logic                   overflow_a;
    logic                   overflow_b;

    modport master (
        output a_x, a_y, a_color, a_write,
        output b_x, b_y, b_color, b_write,
        output clear_overflow,
        input  a_ready, b_ready,
        input  VGA_x, VGA_y, VGA_color, VGA_write,
        input  overflow_a, overflow_b
    );

    modport slave (
        input  a_x, a_y, a_color, a_write,
        input  b_x, b_y, b_color, b_write,
        input  clear_overflow,
        output a_ready, b_ready,
        output VGA_x, VGA_y, VGA_color, VGA_write,
        output overflow_a, overflow_b
    );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is dropped even if a pop happens.
module pixel_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    // Head word is visible combinationally so a pop can be registered on the same edge.
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/pixel_write_arbiter.sv
// Two buffered pixel sources merged round-robin onto one registered VGA write port.
module pixel_write_arbiter
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    pixel_write_arbiter_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] READY_LIMIT = CW'(FIFO_DEPTH - 2);

    logic [PIX_W-1:0] fifo_din   [2];
    logic [PIX_W-1:0] fifo_dout  [2];
    logic [CW-1:0]    fifo_count [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       drop;
    logic [1:0]       ready;
    logic [1:0]       overflow_reg;
    grant_t           last_grant_reg;
    grant_t           last_grant_next;
    logic [PIX_W-1:0] vga_word_reg;
    logic             vga_write_reg;
    pixel_t           vga_pix;

    assign fifo_din[0] = pack_pixel(bus.a_x, bus.a_y, bus.a_color);
    assign fifo_din[1] = pack_pixel(bus.b_x, bus.b_y, bus.b_color);
    assign push        = {bus.b_write, bus.a_write};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            pixel_fifo #(
                .WIDTH (PIX_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .Clock  (Clock),
                .Resetn (Resetn),
                .push   (push[gi]),
                .pop    (pop[gi]),
                .din    (fifo_din[gi]),
                .dout   (fifo_dout[gi]),
                .count  (fifo_count[gi]),
                .full   (full[gi]),
                .empty  (empty[gi])
            );
            assign drop[gi]  = push[gi] && full[gi];
            // Two-entry margin lets a source that reacts one cycle late still fit.
            assign ready[gi] = (fifo_count[gi] < READY_LIMIT);
        end
    endgenerate

    // Round-robin: on a tie the source that was not served last wins.
    always_comb begin
        pop             = 2'b00;
        last_grant_next = last_grant_reg;
        if (!empty[0] && !empty[1]) begin
            if (last_grant_reg == GRANT_B) begin
                pop[0] = 1'b1;
            end else begin
                pop[1] = 1'b1;
            end
        end else if (!empty[0]) begin
            pop[0] = 1'b1;
        end else if (!empty[1]) begin
            pop[1] = 1'b1;
        end
        if (pop[0]) begin
            last_grant_next = GRANT_A;
        end else if (pop[1]) begin
            last_grant_next = GRANT_B;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            last_grant_reg <= GRANT_B;
            vga_word_reg   <= '0;
            vga_write_reg  <= 1'b0;
            overflow_reg   <= 2'b00;
        end else begin
            last_grant_reg <= last_grant_next;
            vga_write_reg  <= |pop;
            if (|pop) begin
                vga_word_reg <= pop[0] ? fifo_dout[0] : fifo_dout[1];
            end
            // A drop on the same edge as a clear keeps the flag set.
            for (int i = 0; i < 2; i++) begin
                if (drop[i]) begin
                    overflow_reg[i] <= 1'b1;
                end else if (bus.clear_overflow) begin
                    overflow_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign vga_pix        = unpack_pixel(vga_word_reg);
    assign bus.VGA_x      = vga_pix.x;
    assign bus.VGA_y      = vga_pix.y;
    assign bus.VGA_color  = vga_pix.color;
    assign bus.VGA_write  = vga_write_reg;
    assign bus.overflow_a = overflow_reg[0];
    assign bus.overflow_b = overflow_reg[1];
    assign bus.a_ready    = ready[0];
    assign bus.b_ready    = ready[1];
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench: the driver queues expected VGA words, a negedge monitor pops and compares.
module tb_pixel_write_arbiter;
    import vga_pkg::*;

    localparam int DEPTH = 16;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    pixel_write_arbiter_if bus();

    pixel_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [PIX_W-1:0] exp_q [$];
    logic [PIX_W-1:0] qa [$];
    logic [PIX_W-1:0] qb [$];
    logic [PIX_W-1:0] last_emitted = '0;
    bit m_lg  = 1'b1;
    bit m_ova = 1'b0;
    bit m_ovb = 1'b0;
    int seq   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic logic [PIX_W-1:0] mk(input bit src);
        logic [PIX_W-1:0] w;
        w = pack_pixel(10'(seq), src ? 9'd300 : 9'd100, 9'(seq * 7 + 3));
        seq++;
        return w;
    endfunction

    // Monitor: every plot strobe must match the next expected word.
    always @(negedge Clock) begin
        logic [PIX_W-1:0] got;
        logic [PIX_W-1:0] w;
        if (Resetn && bus.VGA_write) begin
            got = pack_pixel(bus.VGA_x, bus.VGA_y, bus.VGA_color);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got=%h required=none", got);
            end else begin
                w = exp_q.pop_front();
                last_emitted = w;
                if (got !== w) begin
                    errors++;
                    $display("FAIL vga_word got=%h required=%h", got, w);
                end else begin
                    $display("out x=%0d y=%0d color=%h", bus.VGA_x, bus.VGA_y, bus.VGA_color);
                end
            end
        end
    end

    // One clock: drive inputs, advance the reference queues, step past the edge, check flags.
    task automatic cycle(input logic aw, input logic [PIX_W-1:0] aword,
                         input logic bw, input logic [PIX_W-1:0] bword, input logic clr);
        pixel_t pa_w;
        pixel_t pb_w;
        bit pa, pb, da, db;
        pa_w = unpack_pixel(aword);
        pb_w = unpack_pixel(bword);
        bus.a_x = pa_w.x;  bus.a_y = pa_w.y;  bus.a_color = pa_w.color;  bus.a_write = aw;
        bus.b_x = pb_w.x;  bus.b_y = pb_w.y;  bus.b_color = pb_w.color;  bus.b_write = bw;
        bus.clear_overflow = clr;
        pa = 0;
        pb = 0;
        if (qa.size() > 0 && qb.size() > 0) begin
            if (m_lg) pa = 1; else pb = 1;
        end else if (qa.size() > 0) begin
            pa = 1;
        end else if (qb.size() > 0) begin
            pb = 1;
        end
        da = aw && (qa.size() == DEPTH);
        db = bw && (qb.size() == DEPTH);
        if (pa) begin exp_q.push_back(qa.pop_front()); m_lg = 0; end
        if (pb) begin exp_q.push_back(qb.pop_front()); m_lg = 1; end
        if (aw && !da) qa.push_back(aword);
        if (bw && !db) qb.push_back(bword);
        if (da) m_ova = 1; else if (clr) m_ova = 0;
        if (db) m_ovb = 1; else if (clr) m_ovb = 0;
        @(posedge Clock);
        #1;
        chk("a_ready", 32'(bus.a_ready), 32'(qa.size() < DEPTH - 2));
        chk("b_ready", 32'(bus.b_ready), 32'(qb.size() < DEPTH - 2));
        chk("overflow_a", 32'(bus.overflow_a), 32'(m_ova));
        chk("overflow_b", 32'(bus.overflow_b), 32'(m_ovb));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_VGA_x"}, 32'(bus.VGA_x), 32'd0);
        chk({tag, "_VGA_y"}, 32'(bus.VGA_y), 32'd0);
        chk({tag, "_VGA_color"}, 32'(bus.VGA_color), 32'd0);
        chk({tag, "_VGA_write"}, 32'(bus.VGA_write), 32'd0);
        chk({tag, "_overflow"}, 32'({bus.overflow_a, bus.overflow_b}), 32'd0);
        chk({tag, "_ready"}, 32'({bus.a_ready, bus.b_ready}), 32'd3);
    endtask

    // Asynchronous assert between edges, release away from the edge.
    task automatic apply_reset(input string tag);
        @(negedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        check_reset_outputs(tag);
        qa.delete();
        qb.delete();
        exp_q.delete();
        m_lg  = 1;
        m_ova = 0;
        m_ovb = 0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    initial begin
        logic [PIX_W-1:0] w1;
        logic [PIX_W-1:0] aw_q [3];
        logic [PIX_W-1:0] bw_q [3];
        logic [PIX_W-1:0] order [6];
        bit clr_done;
        bit a_low_seen;
        bit clr;

        bus.a_x = '0; bus.a_y = '0; bus.a_color = '0; bus.a_write = 1'b0;
        bus.b_x = '0; bus.b_y = '0; bus.b_color = '0; bus.b_write = 1'b0;
        bus.clear_overflow = 1'b0;
        apply_reset("reset");
        check_reset_outputs("post_reset");

        // Single A pixel: strobe appears one cycle after the pop edge, for one cycle.
        w1 = pack_pixel(10'd150, 9'd360, 9'h1C7);
        cycle(1'b1, w1, 1'b0, '0, 1'b0);
        chk("lat_edge_k_write", 32'(bus.VGA_write), 32'd0);
        idle(1);
        chk("lat_edge_k1_write", 32'(bus.VGA_write), 32'd1);
        chk("single_x", 32'(bus.VGA_x), 32'd150);
        chk("single_y", 32'(bus.VGA_y), 32'd360);
        chk("single_color", 32'(bus.VGA_color), 32'h1C7);
        idle(1);
        chk("single_strobe_end", 32'(bus.VGA_write), 32'd0);
        idle(2);

        // Simultaneous three-pixel bursts from a fresh reset interleave A0,B0,A1,B1,A2,B2.
        apply_reset("reset2");
        for (int i = 0; i < 3; i++) begin
            aw_q[i] = mk(1'b0);
            bw_q[i] = mk(1'b1);
            order[2*i]   = aw_q[i];
            order[2*i+1] = bw_q[i];
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 3) cycle(1'b1, aw_q[i], 1'b1, bw_q[i], 1'b0);
            else       idle(1);
            chk($sformatf("rr_write_%0d", i), 32'(bus.VGA_write), 32'(i >= 1 && i <= 6));
            if (i >= 1 && i <= 6)
                chk($sformatf("rr_word_%0d", i), 32'(pack_pixel(bus.VGA_x, bus.VGA_y, bus.VGA_color)),
                    32'(order[i-1]));
        end

        // Both sources saturated: A fills, drops, and a clear on a drop edge is overridden.
        clr_done   = 0;
        a_low_seen = 0;
        for (int k = 0; k < 40; k++) begin
            clr = !clr_done && (qa.size() == DEPTH);
            cycle(1'b1, mk(1'b0), 1'b1, mk(1'b1), clr);
            if (!bus.a_ready) a_low_seen = 1;
            if (clr) begin
                clr_done = 1;
                chk("clear_vs_drop_a", 32'(bus.overflow_a), 32'd1);
            end
        end
        chk("a_ready_went_low", 32'(a_low_seen), 32'd1);
        chk("clear_on_drop_edge_seen", 32'(clr_done), 32'd1);
        chk("overflow_a_set", 32'(bus.overflow_a), 32'd1);
        chk("overflow_b_set", 32'(bus.overflow_b), 32'd1);
        idle(40);
        chk("drained_a_ready", 32'(bus.a_ready), 32'd1);

        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        chk("clear_overflow_a", 32'(bus.overflow_a), 32'd0);
        chk("clear_overflow_b", 32'(bus.overflow_b), 32'd0);

        // Long idle: strobe stays low and the last pixel is held.
        for (int i = 0; i < 100; i++) begin
            idle(1);
            chk("idle_write", 32'(bus.VGA_write), 32'd0);
        end
        chk("hold_word", 32'(pack_pixel(bus.VGA_x, bus.VGA_y, bus.VGA_color)), 32'(last_emitted));

        // Reset with eight pixels buffered: nothing stale emerges afterwards.
        for (int k = 0; k < 7; k++) cycle(1'b1, mk(1'b0), 1'b1, mk(1'b1), 1'b0);
        chk("buffered_before_reset", 32'(qa.size() + qb.size()), 32'd8);
        apply_reset("mid_burst");
        for (int i = 0; i < 20; i++) begin
            idle(1);
            chk("post_reset_idle_write", 32'(bus.VGA_write), 32'd0);
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Merges the pixel-write streams of two independent drawing engines (player sprite engine on port A, obstacle/scenery engine on port B) onto the single write port of the VGA adapter. Each source is buffered in its own FIFO so that bursts from one engine are not lost while the other is being served, and the output stage issues at most one pixel write per cycle under round-robin arbitration. The block sits between the drawing FSMs and the VGA adapter's x/y/colour/plot inputs.

## Interface
- nX, 10: x-coordinate width.
- nY, 9: y-coordinate width.
- COLOR_DEPTH, 9: colour width, RRR_GGG_BBB.
- FIFO_DEPTH, 16: entries per source FIFO; power of two, ≥4.
- Clock  in  1: system clock; all state on rising edge.
- Resetn  in  1: reset, asynchronous, active-low.
- a_x / a_y / a_color  in  nX / nY / COLOR_DEPTH: source A pixel.
- a_write  in  1: source A push request.
- a_ready  out  1: high when A FIFO count < FIFO_DEPTH-2.
- b_x / b_y / b_color / b_write / b_ready: identical set for source B.
- clear_overflow  in  1: clears both sticky overflow flags.
- VGA_x / VGA_y / VGA_color  out  nX / nY / COLOR_DEPTH: registered pixel to adapter.
- VGA_write  out  1: registered plot strobe, one pixel per high cycle.
- overflow_a / overflow_b  out  1: sticky, set when a push was dropped.

## Operation
- Push: at a rising edge with X_write=1, word {x,y,color} is written to FIFO X if its count < FIFO_DEPTH; otherwise dropped and overflow_X set. A push at count==FIFO_DEPTH is dropped even if a pop occurs the same edge.
- a_ready/b_ready are advisory (2-entry margin for one-cycle-late sources); pushes are never gated by them. Engines without backpressure (current player engine emits ≤1 write/cycle for ≤61 cycles per row) rely on depth.
- Arbiter: single state bit last_grant (A=0, B=1). Each edge: if both FIFOs non-empty, pop the one ≠ last_grant; if one non-empty, pop it; if neither, no pop. last_grant updates only on a pop.
- Output register: on pop, VGA_x/y/color ← popped word, VGA_write←1; otherwise VGA_write←0 and x/y/color hold last value.
- Empty-FIFO bypass is not used: every pixel passes through its FIFO.
- clear_overflow: at an edge clears flags; if a drop occurs the same edge, the flag stays set (set wins).
- Ordering: per-source FIFO order preserved; no ordering guarantee between sources.

## Timing
- Reset (async assert, sync-to-clock release): FIFOs empty, pointers/counts 0, last_grant=1 (so A wins first tie), VGA_x=0, VGA_y=0, VGA_color=0, VGA_write=0, overflow_a=overflow_b=0, a_ready=b_ready=1. Reset mid-burst discards all buffered pixels.
- Latency: push at edge k into empty FIFO → popped at edge k+1 → VGA_write high in cycle after edge k+1 (2-edge latency, no idle-path shortcut).
- Throughput: one pixel/cycle aggregate; with both sources saturated each gets every other cycle.
- Simultaneous push and pop on same FIFO: both take effect; count unchanged (except full case above).
- Pointer wrap: log2(FIFO_DEPTH)-bit pointers wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.
- a_ready/b_ready combinational from registered count.

## Structure
- vga_pkg: nX, nY, COLOR_DEPTH, pixel word width (nX+nY+COLOR_DEPTH=28 default), pack/unpack helpers.
- Sub-module pixel_fifo (parameter WIDTH, DEPTH; push, pop, data in/out, count, full, empty), instantiated twice; arbiter and output register in top.

## Test plan
- Single A write (x=150,y=360,color=9'h1C7) after reset → VGA_write high exactly one cycle, 2 edges later, same x/y/color; B idle.
- A and B each push 3 pixels on the same three edges → outputs A0,B0,A1,B1,A2,B2 consecutively, VGA_write high 6 cycles.
- A pushes 20 consecutive writes with B continuously pushing (FIFO_DEPTH=16) → a_ready low at count 14, overflow_a set, accepted A pixels emerge in order, dropped ones never appear.
- clear_overflow pulsed with no concurrent drop → flags 0 next cycle; pulsed on an edge with a drop → flag remains 1.
- Resetn asserted asynchronously mid-burst with 8 pixels buffered → all outputs 0 immediately; after release no stale pixel is emitted.
- Idle 100 cycles after traffic → VGA_write stays 0, VGA_x/y/color hold the last emitted pixel.
